cdb_arbiter: RTL and testbench

- Common Data Bus arbiter and broadcast stage, directly downstream of the functional units (Branch, ALU, load/store).
- Each unit asserts a request when it has a ready reservation-station entry.
- The arbiter grants one unit per cycle round-robin through that unit's `grnt` input. It then captures the unit's registered result and broadcasts it as the single CDB write (valid/index/result/addr) back to every station and to the ROB/PC logic.

---
 rtl/cdb_arbiter.sv | 145 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant to one functional unit per cycle,
// then a wait cycle and a capture cycle that broadcasts the unit's result.
module cdb_arbiter #(
  parameter int N_UNITS = 4,
  parameter int SRC_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   br,
  input  logic [N_UNITS-1:0]     req,
  input  logic [N_UNITS-1:0]     unit_valid,
  input  logic [N_UNITS*8-1:0]   unit_index,
  input  logic [N_UNITS*32-1:0]  unit_result,
  input  logic [N_UNITS*32-1:0]  unit_addr,
  output logic [N_UNITS-1:0]     grnt,
  output logic                   cdb_valid,
  output logic [7:0]             cdb_index,
  output logic [31:0]            cdb_result,
  output logic [31:0]            cdb_addr,
  output logic [SRC_W-1:0]       cdb_src,
  output logic [7:0]             drop_cnt
);

  // Returns {found, idx}: first set bit of elig scanning ptr, ptr+1, ... modulo N_UNITS.
  function automatic logic [SRC_W:0] pick_rr(input logic [N_UNITS-1:0] elig,
                                             input logic [SRC_W-1:0]   ptr);
    int j;
    pick_rr = '0;
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N_UNITS;
      if (elig[j]) pick_rr = {1'b1, SRC_W'(j)};
    end
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SRC_W-1:0]   r_rr_ptr;
  logic [N_UNITS-1:0] r_grnt_p0;
  logic               r_vld_p0;
  logic [SRC_W-1:0]   r_src_p0;
  logic               r_vld_p1;
  logic [SRC_W-1:0]   r_src_p1;
  logic               r_vld_p2;
  logic [7:0]         r_index_p2;
  logic [31:0]        r_result_p2;
  logic [31:0]        r_addr_p2;
  logic [SRC_W-1:0]   r_src_p2;
  logic [7:0]         r_drop_cnt;

  logic [N_UNITS-1:0] w_elig;
  logic [SRC_W:0]     w_pick;
  logic               w_found;
  logic [SRC_W-1:0]   w_pick_idx;
  logic [SRC_W-1:0]   w_next_ptr;
  logic [N_UNITS-1:0] w_onehot;
  logic               w_sel_valid;
  logic [7:0]         w_sel_index;
  logic [31:0]        w_sel_result;
  logic [31:0]        w_sel_addr;

  // The unit granted this cycle is masked so a stale req cannot win twice in a row.
  assign w_elig     = req & ~r_grnt_p0;
  assign w_pick     = pick_rr(w_elig, r_rr_ptr);
  assign w_found    = w_pick[SRC_W];
  assign w_pick_idx = w_pick[SRC_W-1:0];
  assign w_next_ptr = (w_pick_idx == SRC_W'(N_UNITS - 1)) ? '0 : w_pick_idx + 1'b1;
  assign w_onehot   = N_UNITS'(1) << w_pick_idx;

  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_index  = '0;
    w_sel_result = '0;
    w_sel_addr   = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (r_src_p1 == SRC_W'(k)) begin
        w_sel_valid  = unit_valid[k];
        w_sel_index  = unit_index[8*k +: 8];
        w_sel_result = unit_result[32*k +: 32];
        w_sel_addr   = unit_addr[32*k +: 32];
      end
    end
  end

  // Stage p0: grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grnt_p0 <= '0;
      r_vld_p0  <= 1'b0;
      r_src_p0  <= '0;
      r_rr_ptr  <= '0;
    end else if (!br && w_found) begin
      r_grnt_p0 <= w_onehot;
      r_vld_p0  <= 1'b1;
      r_src_p0  <= w_pick_idx;
      r_rr_ptr  <= w_next_ptr;
    end else begin
      r_grnt_p0 <= '0;
      r_vld_p0  <= 1'b0;
    end
  end

  // Stage p1: wait while the granted unit registers its output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1 <= 1'b0;
      r_src_p1 <= '0;
    end else begin
      r_vld_p1 <= r_vld_p0 & ~br;
      r_src_p1 <= r_src_p0;
    end
  end

  // Stage p2: capture and broadcast; a flushed grant is never counted as a drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p2    <= 1'b0;
      r_index_p2  <= '0;
      r_result_p2 <= '0;
      r_addr_p2   <= '0;
      r_src_p2    <= '0;
      r_drop_cnt  <= '0;
    end else if (!br && r_vld_p1 && w_sel_valid) begin
      r_vld_p2    <= 1'b1;
      r_index_p2  <= w_sel_index;
      r_result_p2 <= w_sel_result;
      r_addr_p2   <= w_sel_addr;
      r_src_p2    <= r_src_p1;
    end else begin
      r_vld_p2   <= 1'b0;
      r_index_p2 <= '0;
      if (!br && r_vld_p1) r_drop_cnt <= sat_inc8(r_drop_cnt);
    end
  end

  assign grnt       = r_grnt_p0;
  assign cdb_valid  = r_vld_p2;
  assign cdb_index  = r_index_p2;
  assign cdb_result = r_result_p2;
  assign cdb_addr   = r_addr_p2;
  assign cdb_src    = r_src_p2;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of grants in flight.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            br  = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    unit_valid = '0;
  logic [N*8-1:0]  unit_index = '0;
  logic [N*32-1:0] unit_result = '0;
  logic [N*32-1:0] unit_addr = '0;
  logic [N-1:0]    grnt;
  logic            cdb_valid;
  logic [7:0]      cdb_index;
  logic [31:0]     cdb_result;
  logic [31:0]     cdb_addr;
  logic [SW-1:0]   cdb_src;
  logic [7:0]      drop_cnt;

  cdb_arbiter #(.N_UNITS(N), .SRC_W(SW)) dut (
    .clk(clk), .rst(rst), .br(br), .req(req), .unit_valid(unit_valid),
    .unit_index(unit_index), .unit_result(unit_result), .unit_addr(unit_addr),
    .grnt(grnt), .cdb_valid(cdb_valid), .cdb_index(cdb_index),
    .cdb_result(cdb_result), .cdb_addr(cdb_addr), .cdb_src(cdb_src),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: grants in flight with their age (0 = granted, 1 = waiting), plus broadcast state.
  typedef struct {int src; int age;} fl_t;
  fl_t          fl[$];
  int           m_rr;
  logic [N-1:0] m_grnt;
  logic         m_vld;
  logic [7:0]   m_idx;
  logic [31:0]  m_res;
  logic [31:0]  m_addr;
  int           m_src;
  int           m_drop;
  logic [N-1:0] sampled;

  task automatic check_all(input string pfx);
    chk({pfx, ".grnt"}, 64'(grnt),       64'(m_grnt));
    chk({pfx, ".vld"},  64'(cdb_valid),  64'(m_vld));
    chk({pfx, ".idx"},  64'(cdb_index),  64'(m_idx));
    chk({pfx, ".res"},  64'(cdb_result), 64'(m_res));
    chk({pfx, ".addr"}, 64'(cdb_addr),   64'(m_addr));
    chk({pfx, ".src"},  64'(cdb_src),    64'(m_src));
    chk({pfx, ".drop"}, 64'(drop_cnt),   64'(m_drop));
  endtask

  task automatic model_reset();
    m_rr = 0; m_grnt = '0; m_vld = 1'b0; m_idx = '0; m_res = '0; m_addr = '0;
    m_src = 0; m_drop = 0; sampled = '0;
    fl.delete();
  endtask

  task automatic do_reset(input string pfx);
    rst = 1'b0; br = 1'b0; req = '0; unit_valid = '0;
    unit_index = '0; unit_result = '0; unit_addr = '0;
    #1;
    model_reset();
    check_all(pfx);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input string pfx);
    fl_t          nq[$];
    logic [N-1:0] n_grnt, elig;
    logic         n_vld;
    logic [7:0]   n_idx;
    logic [31:0]  n_res, n_addr;
    int           n_src, n_drop, n_rr;
    n_grnt = '0; n_vld = 1'b0; n_idx = '0; n_res = m_res; n_addr = m_addr;
    n_src = m_src; n_drop = m_drop; n_rr = m_rr;
    if (!br) begin
      foreach (fl[i]) begin
        if (fl[i].age == 1) begin
          if (unit_valid[fl[i].src]) begin
            n_vld  = 1'b1;
            n_idx  = unit_index[8*fl[i].src +: 8];
            n_res  = unit_result[32*fl[i].src +: 32];
            n_addr = unit_addr[32*fl[i].src +: 32];
            n_src  = fl[i].src;
          end else if (n_drop < 255) begin
            n_drop++;
          end
        end else begin
          nq.push_back('{src: fl[i].src, age: 1});
        end
      end
      elig = req & ~m_grnt;
      for (int off = 0; off < N; off++) begin
        int k;
        k = (m_rr + off) % N;
        if (elig[k]) begin
          n_grnt[k] = 1'b1;
          nq.push_back('{src: k, age: 0});
          n_rr = (k + 1) % N;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    sampled = m_grnt;
    fl = nq; m_grnt = n_grnt; m_vld = n_vld; m_idx = n_idx; m_res = n_res;
    m_addr = n_addr; m_src = n_src; m_drop = n_drop; m_rr = n_rr;
    check_all(pfx);
  endtask

  task automatic rand_data(input int k);
    unit_index[8*k +: 8]   = 8'($urandom);
    unit_result[32*k +: 32] = $urandom;
    unit_addr[32*k +: 32]   = $urandom;
  endtask

  // Units that just observed their grant answer (maybe) and may re-request; others may raise req.
  task automatic drive_units(input int p_req, input int p_val, input bit spur);
    for (int k = 0; k < N; k++) begin
      rand_data(k);
      if (sampled[k]) begin
        unit_valid[k] = ($urandom_range(99) < p_val);
        req[k]        = ($urandom_range(99) < p_req);
      end else begin
        unit_valid[k] = spur && ($urandom_range(3) == 0);
        if (!req[k]) req[k] = ($urandom_range(99) < p_req);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Single request
    do_reset("rst0");
    req = 4'b0001;
    step("s1");
    chk("single.grnt", 64'(grnt), 64'h1);
    step("s2");
    chk("single.grnt_off", 64'(grnt), 64'h0);
    req = '0; unit_valid = 4'b0001;
    unit_index[7:0] = 8'h05; unit_result[31:0] = 32'h1234; unit_addr[31:0] = 32'hA0;
    step("s3");
    chk("single.vld", 64'(cdb_valid), 64'h1);
    chk("single.idx", 64'(cdb_index), 64'h05);
    chk("single.res", 64'(cdb_result), 64'h1234);
    chk("single.src", 64'(cdb_src), 64'h0);
    unit_valid = '0;
    step("s4");
    chk("single.vld_off", 64'(cdb_valid), 64'h0);

    // Round-robin fairness with all units requesting
    do_reset("rst1");
    req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      step("rr");
      chk("rr.grnt", 64'(grnt), 64'(1 << (i % 4)));
      if (i >= 2) begin
        chk("rr.vld", 64'(cdb_valid), 64'h1);
        chk("rr.src", 64'(cdb_src), 64'((i - 2) % 4));
      end
      for (int k = 0; k < N; k++) rand_data(k);
      unit_valid = sampled;
    end

    // Back-to-back masking
    do_reset("rst2");
    unit_valid = '0;
    req = 4'b0100;
    step("bb0"); chk("bb.g0", 64'(grnt), 64'h4);
    step("bb1"); chk("bb.g1", 64'(grnt), 64'h0);
    step("bb2"); chk("bb.g2", 64'(grnt), 64'h4);
    req = '0;
    repeat (3) step("bbx");

    // Flush kills an in-flight grant and leaves rr_ptr alone
    do_reset("rst3");
    req = 4'b0010;
    step("fl0"); chk("flush.grnt", 64'(grnt), 64'h2);
    br = 1'b1;
    step("fl1");
    br = 1'b0; req = '0; unit_valid = 4'b0010; rand_data(1);
    step("fl2");
    chk("flush.vld", 64'(cdb_valid), 64'h0);
    chk("flush.drop", 64'(drop_cnt), 64'h0);
    unit_valid = '0; req = 4'b1011;
    step("fl3"); chk("flush.next", 64'(grnt), 64'h8);
    req = '0;
    repeat (3) step("flx");

    // Missing result and saturation of drop_cnt
    do_reset("rst4");
    for (int i = 0; i < 300; i++) begin
      req = 4'b1000; unit_valid = '0;
      step("ms0");
      step("ms1");
      req = '0;
      step("ms2");
      if (i == 0) chk("miss.first", 64'(drop_cnt), 64'h1);
    end
    chk("miss.sat", 64'(drop_cnt), 64'd255);

    // Asynchronous reset mid-flight
    do_reset("rst5");
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step("ar");
      for (int k = 0; k < N; k++) rand_data(k);
      unit_valid = sampled;
    end
    chk("ar.pre_grnt", 64'(grnt != '0), 64'h1);
    chk("ar.pre_vld", 64'(cdb_valid), 64'h1);
    #2;
    do_reset("ar.rst");
    req = 4'b1000;
    step("ar.g"); chk("ar.post_grnt", 64'(grnt), 64'h8);
    req = '0;
    repeat (3) step("arx");

    // Randomized traffic with flushes, spurious unit_valid and one mid-flight reset
    do_reset("rst6");
    for (int i = 0; i < 3000; i++) begin
      br = ($urandom_range(99) < 6);
      drive_units(50, 85, 1'b1);
      step("rnd");
      if (i == 1500) begin
        #2;
        do_reset("rnd.rst");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
